// File: rtl/dma_seq_pkg.sv
// rtl/dma_seq_pkg.sv - shared types and constants for the DMA burst sequencer
package dma_seq_pkg;

  localparam logic [2:0] DMA_SIZE_BYTE  = 3'd0;
  localparam logic [2:0] DMA_SIZE_HWORD = 3'd1;
  localparam logic [2:0] DMA_SIZE_WORD  = 3'd2;
  localparam logic [2:0] DMA_SIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  typedef struct packed {
    logic [2:0]  size;
    logic [31:0] length;
    logic [31:0] index;
  } dma_ctrl_msg_t;

  function automatic dma_ctrl_msg_t mk_ctrl_msg(input logic [2:0] size, input logic [31:0] length,
                                                input logic [31:0] index);
    dma_ctrl_msg_t m;
    m.size   = size;
    m.length = length;
    m.index  = index;
    return m;
  endfunction

endpackage

// File: rtl/dma_ctrl_issuer.sv
// rtl/dma_ctrl_issuer.sv - registered val/msg holder for one DMA ctrl channel
module dma_ctrl_issuer
  import dma_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  dma_ctrl_msg_t i_msg,
  input  logic          i_rdy,
  output logic          o_val,
  output logic [66:0]   o_msg
);

  logic          r_val;
  dma_ctrl_msg_t r_msg;

  // The message is only written on load, so it stays stable for the whole request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val <= 1'b0;
      r_msg <= '0;
    end else if (i_load) begin
      r_val <= 1'b1;
      r_msg <= i_msg;
    end else if (r_val && i_rdy) begin
      r_val <= 1'b0;
    end
  end

  assign o_val = r_val;
  assign o_msg = r_msg;

endmodule

// File: rtl/dma_burst_seq.sv
// rtl/dma_burst_seq.sv - splits a transfer into read/compute/write bursts between ESP DMA and a core
module dma_burst_seq
  import dma_seq_pkg::*;
#(
  parameter int         MAX_BURST = 64,
  parameter int         CNT_W     = 32,
  parameter logic [2:0] DMA_SIZE  = DMA_SIZE_DWORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_start,
  input  logic [31:0] cfg_src_index,
  input  logic [31:0] cfg_dst_index,
  input  logic [31:0] cfg_total_len,
  input  logic [31:0] cfg_burst_len,
  output logic        acc_done,
  output logic        busy,
  output logic        dma_read_ctrl_val,
  input  logic        dma_read_ctrl_rdy,
  output logic [66:0] dma_read_ctrl_msg,
  input  logic        dma_read_chnl_val,
  output logic        dma_read_chnl_rdy,
  input  logic [63:0] dma_read_chnl_msg,
  output logic        core_in_val,
  input  logic        core_in_rdy,
  output logic [63:0] core_in_msg,
  input  logic        core_out_val,
  output logic        core_out_rdy,
  input  logic [63:0] core_out_msg,
  output logic        dma_write_ctrl_val,
  input  logic        dma_write_ctrl_rdy,
  output logic [66:0] dma_write_ctrl_msg,
  output logic        dma_write_chnl_val,
  input  logic        dma_write_chnl_rdy,
  output logic [63:0] dma_write_chnl_msg
);

  state_t           r_state;
  logic             r_start_q, r_armed, r_busy, r_done;
  logic [CNT_W-1:0] r_blen, r_remaining, r_cur, r_cnt, r_rd_idx, r_wr_idx;

  logic             w_start, w_rd_fire, w_wr_fire, w_rd_last, w_wr_last, w_rd_load, w_wr_load;
  logic [CNT_W-1:0] w_cfg_blen, w_first_cur, w_next_rem, w_next_cur;
  dma_ctrl_msg_t    w_rd_msg, w_wr_msg;

  // r_armed blocks a level held high across reset from looking like a fresh start.
  assign w_start     = acc_start && !r_start_q && r_armed;
  assign w_cfg_blen  = (cfg_burst_len == '0 || cfg_burst_len > 32'(MAX_BURST)) ?
                       CNT_W'(MAX_BURST) : CNT_W'(cfg_burst_len);
  assign w_first_cur = (CNT_W'(cfg_total_len) < w_cfg_blen) ? CNT_W'(cfg_total_len) : w_cfg_blen;
  assign w_next_rem  = r_remaining - r_cur;
  assign w_next_cur  = (w_next_rem < r_blen) ? w_next_rem : r_blen;

  assign w_rd_fire = (r_state == ST_RD_DATA) && dma_read_chnl_val && core_in_rdy;
  assign w_wr_fire = (r_state == ST_WR_DATA) && core_out_val && dma_write_chnl_rdy;
  assign w_rd_last = w_rd_fire && (r_cnt == r_cur - CNT_W'(1));
  assign w_wr_last = w_wr_fire && (r_cnt == r_cur - CNT_W'(1));

  assign w_rd_load = ((r_state == ST_IDLE) && w_start && (cfg_total_len != '0)) ||
                     (w_wr_last && (w_next_rem != '0));
  assign w_wr_load = w_rd_last;
  assign w_rd_msg  = (r_state == ST_IDLE) ?
                     mk_ctrl_msg(DMA_SIZE, 32'(w_first_cur), cfg_src_index) :
                     mk_ctrl_msg(DMA_SIZE, 32'(w_next_cur), 32'(r_rd_idx));
  assign w_wr_msg  = mk_ctrl_msg(DMA_SIZE, 32'(r_cur), 32'(r_wr_idx));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_start_q   <= 1'b0;
      r_armed     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_blen      <= '0;
      r_remaining <= '0;
      r_cur       <= '0;
      r_cnt       <= '0;
      r_rd_idx    <= '0;
      r_wr_idx    <= '0;
    end else begin
      r_start_q <= acc_start;
      r_armed   <= r_armed | ~acc_start;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_busy      <= 1'b1;
            r_blen      <= w_cfg_blen;
            r_remaining <= CNT_W'(cfg_total_len);
            r_cur       <= w_first_cur;
            r_rd_idx    <= CNT_W'(cfg_src_index);
            r_wr_idx    <= CNT_W'(cfg_dst_index);
            r_state     <= (cfg_total_len == '0) ? ST_DONE : ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (dma_read_ctrl_val && dma_read_ctrl_rdy) begin
            r_cnt   <= '0;
            r_state <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (w_rd_fire) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_rd_last) begin
              r_rd_idx <= r_rd_idx + r_cur;
              r_state  <= ST_WR_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (dma_write_ctrl_val && dma_write_ctrl_rdy) begin
            r_cnt   <= '0;
            r_state <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (w_wr_fire) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_wr_last) begin
              r_wr_idx    <= r_wr_idx + r_cur;
              r_remaining <= w_next_rem;
              r_cur       <= w_next_cur;
              r_state     <= (w_next_rem == '0) ? ST_DONE : ST_RD_REQ;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  dma_ctrl_issuer u_rd_issuer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_rd_load),
    .i_msg  (w_rd_msg),
    .i_rdy  (dma_read_ctrl_rdy),
    .o_val  (dma_read_ctrl_val),
    .o_msg  (dma_read_ctrl_msg)
  );

  dma_ctrl_issuer u_wr_issuer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_wr_load),
    .i_msg  (w_wr_msg),
    .i_rdy  (dma_write_ctrl_rdy),
    .o_val  (dma_write_ctrl_val),
    .o_msg  (dma_write_ctrl_msg)
  );

  assign core_in_val        = (r_state == ST_RD_DATA) && dma_read_chnl_val;
  assign dma_read_chnl_rdy  = (r_state == ST_RD_DATA) && core_in_rdy;
  assign core_in_msg        = dma_read_chnl_msg;
  assign dma_write_chnl_val = (r_state == ST_WR_DATA) && core_out_val;
  assign core_out_rdy       = (r_state == ST_WR_DATA) && dma_write_chnl_rdy;
  assign dma_write_chnl_msg = core_out_msg;

  assign acc_done = r_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_dma_burst_seq.sv
// tb/tb_dma_burst_seq.sv - scoreboard bench for dma_burst_seq with DMA memory and echo-core models
module tb_dma_burst_seq;

  logic        clk, rst, acc_start;
  logic [31:0] cfg_src_index, cfg_dst_index, cfg_total_len, cfg_burst_len;
  logic        acc_done, busy;
  logic        dma_read_ctrl_val, dma_read_ctrl_rdy;
  logic [66:0] dma_read_ctrl_msg;
  logic        dma_read_chnl_val, dma_read_chnl_rdy;
  logic [63:0] dma_read_chnl_msg;
  logic        core_in_val, core_in_rdy;
  logic [63:0] core_in_msg;
  logic        core_out_val, core_out_rdy;
  logic [63:0] core_out_msg;
  logic        dma_write_ctrl_val, dma_write_ctrl_rdy;
  logic [66:0] dma_write_ctrl_msg;
  logic        dma_write_chnl_val, dma_write_chnl_rdy;
  logic [63:0] dma_write_chnl_msg;

  localparam logic [63:0] XK = 64'hA5A5_0F0F_3C3C_9696;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  bit stall   = 1'b0;

  logic [66:0] exp_rd_ctrl[$];
  logic [66:0] exp_wr_ctrl[$];
  logic [63:0] rd_data_q[$];
  logic [63:0] core_q[$];
  logic [63:0] exp_wdata[$];
  int rd_left = 0, wr_left = 0, rd_beats = 0, rd_bursts = 0;
  int done_cnt = 0, done_cyc = 0, last_wbeat_cyc = 0;
  logic        rd_hold = 1'b0, wr_hold = 1'b0;
  logic [66:0] rd_hold_msg = '0, wr_hold_msg = '0;

  dma_burst_seq dut (
    .clk                (clk),
    .rst                (rst),
    .acc_start          (acc_start),
    .cfg_src_index      (cfg_src_index),
    .cfg_dst_index      (cfg_dst_index),
    .cfg_total_len      (cfg_total_len),
    .cfg_burst_len      (cfg_burst_len),
    .acc_done           (acc_done),
    .busy               (busy),
    .dma_read_ctrl_val  (dma_read_ctrl_val),
    .dma_read_ctrl_rdy  (dma_read_ctrl_rdy),
    .dma_read_ctrl_msg  (dma_read_ctrl_msg),
    .dma_read_chnl_val  (dma_read_chnl_val),
    .dma_read_chnl_rdy  (dma_read_chnl_rdy),
    .dma_read_chnl_msg  (dma_read_chnl_msg),
    .core_in_val        (core_in_val),
    .core_in_rdy        (core_in_rdy),
    .core_in_msg        (core_in_msg),
    .core_out_val       (core_out_val),
    .core_out_rdy       (core_out_rdy),
    .core_out_msg       (core_out_msg),
    .dma_write_ctrl_val (dma_write_ctrl_val),
    .dma_write_ctrl_rdy (dma_write_ctrl_rdy),
    .dma_write_ctrl_msg (dma_write_ctrl_msg),
    .dma_write_chnl_val (dma_write_chnl_val),
    .dma_write_chnl_rdy (dma_write_chnl_rdy),
    .dma_write_chnl_msg (dma_write_chnl_msg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DMA memory, core echo model and channel monitors; inputs change on negedge, handshakes judged 1ns later.
  initial begin
    int          len;
    logic [63:0] d;
    dma_read_ctrl_rdy  = 1'b0;
    dma_write_ctrl_rdy = 1'b0;
    dma_read_chnl_val  = 1'b0;
    dma_read_chnl_msg  = '0;
    core_in_rdy        = 1'b0;
    core_out_val       = 1'b0;
    core_out_msg       = '0;
    dma_write_chnl_rdy = 1'b0;
    forever begin
      @(negedge clk);
      dma_read_ctrl_rdy  = !stall || ($urandom_range(0, 2) == 0);
      dma_write_ctrl_rdy = !stall || ($urandom_range(0, 2) == 0);
      core_in_rdy        = !stall || ($urandom_range(0, 1) == 0);
      dma_write_chnl_rdy = !stall || ($urandom_range(0, 1) == 0);
      if (rd_data_q.size() > 0 && (!stall || $urandom_range(0, 1) == 0)) begin
        dma_read_chnl_val = 1'b1;
        dma_read_chnl_msg = rd_data_q[0];
      end else begin
        dma_read_chnl_val = 1'b0;
        dma_read_chnl_msg = '0;
      end
      if (core_q.size() > 0 && (!stall || $urandom_range(0, 1) == 0)) begin
        core_out_val = 1'b1;
        core_out_msg = core_q[0];
      end else begin
        core_out_val = 1'b0;
        core_out_msg = '0;
      end
      #1;
      if (dma_read_ctrl_val) begin
        if (rd_hold) check("rd_ctrl_stable", dma_read_ctrl_msg, rd_hold_msg);
        if (dma_read_ctrl_rdy) begin
          if (exp_rd_ctrl.size() == 0) check("rd_ctrl_unexpected", dma_read_ctrl_msg, 67'h0);
          else check("rd_ctrl_msg", dma_read_ctrl_msg, exp_rd_ctrl.pop_front());
          len = int'(dma_read_ctrl_msg[63:32]);
          if (len > 1024) len = 1024;
          for (int i = 0; i < len; i++)
            rd_data_q.push_back({dma_read_ctrl_msg[31:0] + 32'(i), 32'hC0DE_0000 ^ 32'(rd_bursts)});
          rd_left += len;
          rd_bursts++;
          rd_hold = 1'b0;
        end else begin
          rd_hold     = 1'b1;
          rd_hold_msg = dma_read_ctrl_msg;
        end
      end else rd_hold = 1'b0;
      if (dma_read_chnl_rdy) check("rd_rdy_gate", 67'(rd_left > 0), 67'(1));
      if (dma_read_chnl_val && dma_read_chnl_rdy) begin
        d = rd_data_q.pop_front();
        check("core_in_pass", {core_in_val, core_in_msg}, {1'b1, d});
        exp_wdata.push_back(d ^ XK);
        rd_left--;
        rd_beats++;
      end
      if (core_in_val && core_in_rdy) core_q.push_back(core_in_msg ^ XK);
      if (dma_write_ctrl_val) begin
        if (wr_hold) check("wr_ctrl_stable", dma_write_ctrl_msg, wr_hold_msg);
        if (dma_write_ctrl_rdy) begin
          if (exp_wr_ctrl.size() == 0) check("wr_ctrl_unexpected", dma_write_ctrl_msg, 67'h0);
          else check("wr_ctrl_msg", dma_write_ctrl_msg, exp_wr_ctrl.pop_front());
          wr_left += int'(dma_write_ctrl_msg[63:32]);
          wr_hold = 1'b0;
        end else begin
          wr_hold     = 1'b1;
          wr_hold_msg = dma_write_ctrl_msg;
        end
      end else wr_hold = 1'b0;
      if (core_out_rdy) check("wr_rdy_gate", 67'(wr_left > 0), 67'(1));
      if (dma_write_chnl_val && dma_write_chnl_rdy) begin
        if (exp_wdata.size() == 0) check("wdata_unexpected", 67'(dma_write_chnl_msg), 67'h0);
        else check("wdata", 67'(dma_write_chnl_msg), 67'(exp_wdata.pop_front()));
        wr_left--;
        last_wbeat_cyc = cyc + 1;
      end
      if (core_out_val && core_out_rdy) void'(core_q.pop_front());
      if (acc_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic flush_env();
    exp_rd_ctrl.delete();
    exp_wr_ctrl.delete();
    rd_data_q.delete();
    core_q.delete();
    exp_wdata.delete();
    rd_left = 0;
    wr_left = 0;
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] total,
                         input logic [31:0] bcfg, input bit do_stall, input bit drop_mid);
    logic [31:0] blen, rem, ri, wi, cur;
    int c0, d0, n;
    blen = (bcfg == 0 || bcfg > 64) ? 32'd64 : bcfg;
    rem  = total;
    ri   = src;
    wi   = dst;
    while (rem != 0) begin
      cur = (rem < blen) ? rem : blen;
      exp_rd_ctrl.push_back({3'd3, cur, ri});
      exp_wr_ctrl.push_back({3'd3, cur, wi});
      ri  += cur;
      wi  += cur;
      rem -= cur;
    end
    stall = do_stall;
    @(negedge clk);
    cfg_src_index = src;
    cfg_dst_index = dst;
    cfg_total_len = total;
    cfg_burst_len = bcfg;
    acc_start     = 1'b1;
    c0 = cyc;
    d0 = done_cnt;
    @(negedge clk);
    #2;
    check("start_busy", 67'(busy), 67'(1));
    check("start_rd_val", 67'(dma_read_ctrl_val), 67'(total != 0));
    // cfg changes after the start edge must have no effect
    cfg_total_len = 32'd7;
    cfg_burst_len = 32'd3;
    n = 0;
    while (done_cnt == d0 && n < 6000) begin
      @(negedge clk);
      #2;
      n++;
      if (drop_mid && n == 3) acc_start = 1'b0;
    end
    check("done_count", 67'(done_cnt - d0), 67'(1));
    if (total == 0) check("done_lat_zero", 67'(done_cyc - c0), 67'(2));
    else check("done_lat", 67'(done_cyc - last_wbeat_cyc), 67'(1));
    check("busy_clear", 67'(busy), 67'(0));
    check("rd_ctrl_left", 67'(exp_rd_ctrl.size()), 67'(0));
    check("wr_ctrl_left", 67'(exp_wr_ctrl.size()), 67'(0));
    check("wdata_left", 67'(exp_wdata.size()), 67'(0));
    check("beats_left", 67'({rd_left[15:0], wr_left[15:0]}), 67'(0));
    repeat (4) @(negedge clk);
    #2;
    check("no_restart", 67'(done_cnt - d0), 67'(1));
    check("idle_quiet", 67'({dma_read_ctrl_val, busy}), 67'(0));
    acc_start = 1'b0;
    flush_env();
  endtask

  initial begin
    int b0, n;
    rst           = 1'b0;
    acc_start     = 1'b0;
    cfg_src_index = '0;
    cfg_dst_index = '0;
    cfg_total_len = '0;
    cfg_burst_len = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_ctrl", 67'({dma_read_ctrl_val, dma_write_ctrl_val, acc_done, busy}), 67'(0));
    check("rst_chnl", 67'({dma_read_chnl_rdy, core_in_val, core_out_rdy, dma_write_chnl_val}), 67'(0));
    check("rst_rd_msg", dma_read_ctrl_msg, 67'h0);
    check("rst_wr_msg", dma_write_ctrl_msg, 67'h0);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    run_job(32'h100, 32'h800, 32'd128, 32'd64, 1'b0, 1'b0);
    run_job(32'h1000, 32'h2000, 32'd100, 32'd64, 1'b0, 1'b0);
    run_job(32'h5, 32'h9, 32'd0, 32'd64, 1'b0, 1'b0);
    run_job(32'h0, 32'h400, 32'd200, 32'd0, 1'b0, 1'b0);
    run_job(32'h0, 32'h400, 32'd200, 32'd500, 1'b1, 1'b1);
    run_job(32'hFFFF_FFF0, 32'hFFFF_FFE0, 32'd40, 32'd16, 1'b1, 1'b0);
    run_job(32'h40, 32'h80, 32'd1, 32'd1, 1'b1, 1'b0);

    // reset in the middle of a read burst
    stall = 1'b0;
    exp_rd_ctrl.push_back({3'd3, 32'd64, 32'h10});
    @(negedge clk);
    cfg_src_index = 32'h10;
    cfg_dst_index = 32'h20;
    cfg_total_len = 32'd128;
    cfg_burst_len = 32'd64;
    acc_start     = 1'b1;
    b0 = rd_beats;
    n  = 0;
    while (rd_beats < b0 + 5 && n < 500) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("rst_reach_rd", 67'(rd_beats >= b0 + 5), 67'(1));
    check("pre_rst_rd_data", 67'(dma_read_chnl_rdy), 67'(1));
    #1 rst = 1'b0;
    #1;
    check("midrst_ctrl", 67'({dma_read_ctrl_val, dma_write_ctrl_val, acc_done, busy}), 67'(0));
    check("midrst_chnl", 67'({dma_read_chnl_rdy, core_in_val, core_out_rdy, dma_write_chnl_val}), 67'(0));
    check("midrst_msgs", dma_read_ctrl_msg | dma_write_ctrl_msg, 67'h0);
    flush_env();
    @(negedge clk);
    #3 rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #2;
      check("post_rst_hold", 67'({dma_read_ctrl_val, busy}), 67'(0));
    end
    acc_start = 1'b0;
    run_job(32'h300, 32'h700, 32'd70, 32'd32, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_burst_seq.md
Name: dma_burst_seq

Overview:
- Sequencer between the ESP DMA interface and an HLS compute core (Top_rtl-style datapath).
- On accelerator start, splits a transfer of cfg_total_len 64-bit words into bursts.
- Per burst: issues a read request, streams read data into the core, issues a write request, then drains core results to memory.
- Raises acc_done when all bursts complete. It is the block that owns the DMA handshakes on behalf of the core.

Parameters:
- MAX_BURST, 64, maximum words per burst; also used when cfg_burst_len is 0.
- CNT_W, 32, width of the word counters and index arithmetic.
- DMA_SIZE, 3'b011, DMA size code placed on ctrl msgs (64-bit beats).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- acc_start  in  1  conf_done level; a rising edge starts a run
- cfg_src_index  in  32  first read word index
- cfg_dst_index  in  32  first write word index
- cfg_total_len  in  32  total words to process
- cfg_burst_len  in  32  words per burst (0 -> MAX_BURST)
- acc_done  out  1  one-cycle completion pulse
- busy  out  1  high from start until the done pulse
- dma_read_ctrl_val  out  1
- dma_read_ctrl_rdy  in  1
- dma_read_ctrl_msg  out  67  {size[2:0], length[31:0], index[31:0]}
- dma_read_chnl_val  in  1
- dma_read_chnl_rdy  out  1
- dma_read_chnl_msg  in  64
- core_in_val  out  1
- core_in_rdy  in  1
- core_in_msg  out  64
- core_out_val  in  1
- core_out_rdy  out  1
- core_out_msg  in  64
- dma_write_ctrl_val  out  1
- dma_write_ctrl_rdy  in  1
- dma_write_ctrl_msg  out  67  same packing as read ctrl
- dma_write_chnl_val  out  1
- dma_write_chnl_rdy  in  1
- dma_write_chnl_msg  out  64

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low.
- Reset values: all val/rdy outputs 0, acc_done 0, busy 0, ctrl msgs 0, state IDLE, counters 0, start-edge register 0.
- Start and configuration: the start edge is acc_start high while the registered copy is low. cfg_* are sampled into registers on the start edge and are ignored thereafter.
- Effective burst length: blen = (cfg_burst_len == 0 || cfg_burst_len > MAX_BURST) ? MAX_BURST : cfg_burst_len. remaining = cfg_total_len.
- IDLE:
  - start edge with total_len == 0 -> DONE.
  - start edge otherwise -> RD_REQ.
  - busy is set on the start edge.
- RD_REQ:
  - cur = min(blen, remaining).
  - dma_read_ctrl_val = 1 with {DMA_SIZE, cur, rd_idx}.
  - Message is registered and stable while val is high.
  - On val&&rdy -> RD_DATA, beat counter = 0.
- RD_DATA: combinational pass-through.
  - core_in_val = dma_read_chnl_val, dma_read_chnl_rdy = core_in_rdy, core_in_msg = dma_read_chnl_msg.
  - Count accepted beats. On the cur-th beat -> WR_REQ, rd_idx += cur.
- WR_REQ:
  - dma_write_ctrl_val = 1 with {DMA_SIZE, cur, wr_idx}.
  - On val&&rdy -> WR_DATA, beat counter = 0.
- WR_DATA: combinational pass-through.
  - dma_write_chnl_val = core_out_val, core_out_rdy = dma_write_chnl_rdy, dma_write_chnl_msg = core_out_msg.
  - On the cur-th beat: wr_idx += cur, remaining -= cur.
  - Then remaining == 0 -> DONE, else -> RD_REQ.
- Outside the matching pass-through state, every chnl/core rdy and val is 0. Core results are never accepted before the write request is granted.
- DONE: acc_done = 1 for exactly one cycle, busy = 0, -> IDLE.
  - A new run requires acc_start to fall and rise again.
  - acc_start held high after done does not restart.
- Final short burst: remaining < blen -> cur = remaining, e.g. total 100 with blen 64 gives 64 then 36.
- acc_start falling mid-run: ignored, and the run completes.
- Index arithmetic: modulo 2^32, wraps silently.
- Reset assertion mid-run: immediate return to reset values. Outstanding DMA transactions are abandoned, and the system resets the DMA engine concurrently.
- Latency: start edge to read ctrl val is 1 cycle. Final write beat to acc_done is 1 cycle.

Decomposition:
- Shared package dma_seq_pkg holds:
  - state enum (IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE);
  - DMA_SIZE_* codes (BYTE=0, HWORD=1, WORD=2, DWORD=3);
  - dma_ctrl_msg_t packed struct {size, length, index} (67 bits).
- One sub-module: dma_ctrl_issuer.
  - Holds a registered val/msg for a ctrl channel.
  - Instantiated twice, once for read and once for write.

Test Plan:
- total=128, burst=64, src=0x100, dst=0x800, core echo:
  - read ctrl (3,64,0x100), 64 beats, write ctrl (3,64,0x800), 64 beats;
  - then (3,64,0x140) and (3,64,0x840);
  - acc_done pulses once, 1 cycle after the last write beat.
- total=100, burst=64 -> bursts of 64 then 36; second read index src+64.
- total=0 -> no ctrl val ever; acc_done pulses 2 cycles after the start edge.
- burst=0 and burst=500 with total=200 -> bursts of 64, 64, 64, 8.
- Random val/rdy stalls on every channel -> data order preserved, beat counts exact, ctrl msgs stable while val is high.
- rst low during RD_DATA -> all outputs 0 in the same cycle.
  - After release, acc_start held high does not restart.
  - A new rising edge runs to completion.
